dw_bc4_chain: RTL

Parametrised observe-only boundary scan segment: WIDTH BC_4-style cells in one block, for groups of performance-sensitive inputs (clock buses, high-speed data pins). System data passes straight through to the core. The capture chain adds three features: MISR compaction mode, a 1-bit bypass path, and a shift counter that flags a complete unload. It sits in the boundary scan chain between the previous segment's `so` and the next segment's `si`.

---
 rtl/dw_bc_pkg.sv | 23 ++
 rtl/dw_bc_shift_ctr.sv | 46 ++++
 rtl/dw_bc4_chain.sv | 97 +++++++++
 3 files changed

// File: rtl/dw_bc_pkg.sv
// ---------------------------------------------------------------------------
// dw_bc_pkg
// Shared definitions for the observe-only boundary scan cell segments.
//   BC_MODE_*  : encodings of the 2-bit mode input (2'b11 behaves as normal)
//   bc_clog2() : ceiling log2, used to size the shift counter
// ---------------------------------------------------------------------------
package dw_bc_pkg;

  localparam logic [1:0] BC_MODE_NORM = 2'b00;
  localparam logic [1:0] BC_MODE_MISR = 2'b01;
  localparam logic [1:0] BC_MODE_BYP  = 2'b10;

  // Ceiling log2 of n; returns 0 for n <= 1.
  function automatic int bc_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dw_bc_shift_ctr.sv
// ---------------------------------------------------------------------------
// dw_bc_shift_ctr
// Saturating shift counter. Counts enabled cycles since the last clear and
// stops at LIMIT; o_done flags that the count has reached LIMIT.
//   clk    : clock, all updates on rising edge
//   rst    : synchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear (count -> 0), lower priority than rst
//   i_en   : count enable
//   o_cnt  : current count
//   o_done : high when o_cnt == LIMIT
// ---------------------------------------------------------------------------
module dw_bc_shift_ctr
  import dw_bc_pkg::*;
#(
  parameter int LIMIT = 8,
  parameter int CW    = bc_clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_done
);

  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = w_at_limit;

endmodule

// File: rtl/dw_bc4_chain.sv
// ---------------------------------------------------------------------------
// dw_bc4_chain
// WIDTH observe-only (BC_4 style) boundary scan cells in one segment, with
// optional MISR compaction, a 1-bit bypass flop and an unload counter.
// System data is never gated: data_out is a wire copy of data_in.
//   capture_clk : clock, all state updates on rising edge
//   rst         : synchronous active-high reset, highest priority
//   capture_en  : active-low enable (1 = hold every bit of state)
//   shift_dr    : 1 = shift toward so, 0 = capture
//   mode        : 00 normal, 01 MISR, 10 bypass, 11 normal
//   si / so     : serial chain in / out
//   data_in     : system pins
//   data_out    : to core, combinational copy of data_in
//   shift_cnt   : shifts since last capture, saturates at WIDTH
//   shift_done  : shift_cnt == WIDTH
// ---------------------------------------------------------------------------
module dw_bc4_chain
  import dw_bc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D)
) (
  input  logic                            capture_clk,
  input  logic                            rst,
  input  logic                            capture_en,
  input  logic                            shift_dr,
  input  logic [1:0]                      mode,
  input  logic                            si,
  input  logic [WIDTH-1:0]                data_in,
  output logic [WIDTH-1:0]                data_out,
  output logic                            so,
  output logic [bc_clog2(WIDTH+1)-1:0]    shift_cnt,
  output logic                            shift_done
);

  localparam int CW = bc_clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_cap;
  logic             r_byp;

  logic             w_act;
  logic             w_byp_mode;
  logic             w_misr_mode;
  logic [WIDTH-1:0] w_misr_next;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  assign w_act       = !capture_en;
  assign w_byp_mode  = (mode == BC_MODE_BYP);
  assign w_misr_mode = (mode == BC_MODE_MISR);

  // Galois-style MISR step: shift left, fold the dropped MSB back through
  // POLY, then XOR in the new observation. Pure XOR, no carries.
  assign w_misr_next = {r_cap[WIDTH-2:0], 1'b0}
                     ^ (r_cap[WIDTH-1] ? POLY : '0)
                     ^ data_in;

  // Cell array. In bypass mode the cap register is untouched, so a MISR
  // signature or captured pattern survives a detour through bypass.
  always_ff @(posedge capture_clk) begin
    if (rst) begin
      r_cap <= '0;
      r_byp <= 1'b0;
    end else if (w_act) begin
      if (w_byp_mode) begin
        r_byp <= shift_dr ? si : 1'b0;
      end else if (shift_dr) begin
        r_cap <= {r_cap[WIDTH-2:0], si};
      end else if (w_misr_mode) begin
        r_cap <= w_misr_next;
      end else begin
        r_cap <= data_in;
      end
    end
  end

  // The counter only tracks the cap chain; bypass activity leaves it alone.
  assign w_cnt_clr = w_act && !w_byp_mode && !shift_dr;
  assign w_cnt_en  = w_act && !w_byp_mode &&  shift_dr;

  dw_bc_shift_ctr #(
    .LIMIT (WIDTH),
    .CW    (CW)
  ) u_shift_ctr (
    .clk    (capture_clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (shift_cnt),
    .o_done (shift_done)
  );

  // Both so sources are flops; only the selection follows the mode pins.
  assign so       = w_byp_mode ? r_byp : r_cap[WIDTH-1];
  assign data_out = data_in;

endmodule
